// File: rtl/mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter
//
// Shares the single main data blockram port between the CPU data port
// (read/write) and the video fetch engine (read-only). Ownership is
// round-robin on ties, and an owner may keep the port indefinitely while
// uncontended. Under contention an owner is limited to MAX_HOLD consecutive
// accesses before the port passes directly to the waiting requester. Read
// valids are delayed one cycle to line up with the synchronous blockram
// read latency.
//
// Optional build macro:
//   ARB_STATS_EN - when defined, Contention_Cnt counts cycles in which one
//                  requester waits while the other holds the grant
//                  (saturating at 0xFFFF, cleared by reset). When undefined,
//                  Contention_Cnt is tied to zero. Port list is identical.
//
// Parameters:
//   ADDR_W    address bus width
//   DATA_W    data bus width
//   MAX_HOLD  max consecutive accesses by one owner while the other waits
//             (1..255)
//
// Ports:
//   clk             system clock, rising edge
//   reset           synchronous active-high reset
//   CPU_Req         CPU access request
//   CPU_Wr_En       CPU access is a write
//   CPU_Addr        CPU address
//   CPU_Data_In     CPU write data
//   CPU_Grant       CPU owns the port
//   CPU_Data_Out    read data to CPU
//   CPU_Data_Valid  CPU read data valid (read accepted last cycle)
//   Vid_Req         video read request
//   Vid_Addr        video address
//   Vid_Grant       video owns the port
//   Vid_Data_Out    read data to video
//   Vid_Data_Valid  video read data valid (read accepted last cycle)
//   Mem_Addr        blockram address
//   Mem_Data_Out    blockram write data
//   Mem_Wr_En       blockram write enable
//   Mem_Data_In     blockram read data (one cycle after address)
//   Contention_Cnt  contention statistic
// ---------------------------------------------------------------------------
module mem_port_arbiter #(
    parameter int ADDR_W   = 16,
    parameter int DATA_W   = 16,
    parameter int MAX_HOLD = 8
) (
    input  logic              clk,
    input  logic              reset,

    input  logic              CPU_Req,
    input  logic              CPU_Wr_En,
    input  logic [ADDR_W-1:0] CPU_Addr,
    input  logic [DATA_W-1:0] CPU_Data_In,
    output logic              CPU_Grant,
    output logic [DATA_W-1:0] CPU_Data_Out,
    output logic              CPU_Data_Valid,

    input  logic              Vid_Req,
    input  logic [ADDR_W-1:0] Vid_Addr,
    output logic              Vid_Grant,
    output logic [DATA_W-1:0] Vid_Data_Out,
    output logic              Vid_Data_Valid,

    output logic [ADDR_W-1:0] Mem_Addr,
    output logic [DATA_W-1:0] Mem_Data_Out,
    output logic              Mem_Wr_En,
    input  logic [DATA_W-1:0] Mem_Data_In,

    output logic [15:0]       Contention_Cnt
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CPU_OWN = 2'd1,
        ST_VID_OWN = 2'd2
    } state_t;

    localparam int              HOLD_W   = 8;
    localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(MAX_HOLD);

    // Saturating increment of the burst hold counter.
    function automatic logic [HOLD_W-1:0] sat_hold_inc(input logic [HOLD_W-1:0] v);
        logic [HOLD_W-1:0] res;
        if (v >= HOLD_MAX) begin
            res = HOLD_MAX;
        end else begin
            res = v + 8'd1;
        end
        return res;
    endfunction

    state_t              r_state;
    state_t              w_state_nxt;
    logic                r_last_vid;      // 1: video was served last
    logic                w_last_vid_nxt;
    logic [HOLD_W-1:0]   r_hold;
    logic [HOLD_W-1:0]   w_hold_acc;      // hold count including this cycle's access
    logic                w_hold_hit;
    logic                w_cpu_acc;
    logic                w_vid_acc;
    logic [ADDR_W-1:0]   r_addr_last;
    logic [ADDR_W-1:0]   w_mem_addr;
    logic                r_cpu_vld_p1;
    logic                r_vid_vld_p1;

    // ---- stage p0: ownership decode, access detection, port mux ----------
    assign CPU_Grant = (r_state == ST_CPU_OWN);
    assign Vid_Grant = (r_state == ST_VID_OWN);

    assign w_cpu_acc = CPU_Grant && CPU_Req;
    assign w_vid_acc = Vid_Grant && Vid_Req;

    assign w_hold_acc = (w_cpu_acc || w_vid_acc) ? sat_hold_inc(r_hold) : r_hold;
    assign w_hold_hit = (w_hold_acc >= HOLD_MAX);

    always_comb begin
        w_mem_addr = r_addr_last;
        case (r_state)
            ST_CPU_OWN: w_mem_addr = CPU_Addr;
            ST_VID_OWN: w_mem_addr = Vid_Addr;
            default:    w_mem_addr = r_addr_last;
        endcase
    end

    assign Mem_Addr     = w_mem_addr;
    assign Mem_Data_Out = CPU_Data_In;
    assign Mem_Wr_En    = w_cpu_acc && CPU_Wr_En;

    // Next-state / round-robin bookkeeping.
    always_comb begin
        w_state_nxt    = r_state;
        w_last_vid_nxt = r_last_vid;
        case (r_state)
            ST_IDLE: begin
                if (CPU_Req && Vid_Req) begin
                    w_state_nxt = r_last_vid ? ST_CPU_OWN : ST_VID_OWN;
                end else if (CPU_Req) begin
                    w_state_nxt = ST_CPU_OWN;
                end else if (Vid_Req) begin
                    w_state_nxt = ST_VID_OWN;
                end
            end
            ST_CPU_OWN: begin
                if (CPU_Req) begin
                    // Uncontended bursts never hit the hold limit.
                    if (Vid_Req && w_hold_hit) begin
                        w_state_nxt    = ST_VID_OWN;
                        w_last_vid_nxt = 1'b0;
                    end
                end else begin
                    w_state_nxt    = Vid_Req ? ST_VID_OWN : ST_IDLE;
                    w_last_vid_nxt = 1'b0;
                end
            end
            ST_VID_OWN: begin
                if (Vid_Req) begin
                    if (CPU_Req && w_hold_hit) begin
                        w_state_nxt    = ST_CPU_OWN;
                        w_last_vid_nxt = 1'b1;
                    end
                end else begin
                    w_state_nxt    = CPU_Req ? ST_CPU_OWN : ST_IDLE;
                    w_last_vid_nxt = 1'b1;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_last_vid <= 1'b1;
            r_hold     <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_last_vid <= w_last_vid_nxt;
            if (w_state_nxt != r_state) begin
                r_hold <= '0;
            end else begin
                r_hold <= w_hold_acc;
            end
        end
    end

    // Address seen by the blockram is kept steady while idle.
    always_ff @(posedge clk) begin
        r_addr_last <= w_mem_addr;
    end

    // ---- stage p1: blockram read data returns ------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cpu_vld_p1 <= 1'b0;
            r_vid_vld_p1 <= 1'b0;
        end else begin
            r_cpu_vld_p1 <= w_cpu_acc && !CPU_Wr_En;
            r_vid_vld_p1 <= w_vid_acc;
        end
    end

    assign CPU_Data_Valid = r_cpu_vld_p1;
    assign Vid_Data_Valid = r_vid_vld_p1;
    assign CPU_Data_Out   = Mem_Data_In;
    assign Vid_Data_Out   = Mem_Data_In;

`ifdef ARB_STATS_EN
    // Saturating increment of the contention statistic.
    function automatic logic [15:0] sat_cnt_inc(input logic [15:0] v);
        logic [15:0] res;
        if (v == 16'hFFFF) begin
            res = v;
        end else begin
            res = v + 16'd1;
        end
        return res;
    endfunction

    logic [15:0] r_contention;
    logic        w_contend;

    assign w_contend = (CPU_Req && !CPU_Grant && Vid_Grant) ||
                       (Vid_Req && !Vid_Grant && CPU_Grant);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_contention <= '0;
        end else if (w_contend) begin
            r_contention <= sat_cnt_inc(r_contention);
        end
    end

    assign Contention_Cnt = r_contention;
`else
    assign Contention_Cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_port_arbiter
//
// Bench for mem_port_arbiter. A behavioural synchronous blockram sits on the
// memory port; read accesses are pushed into per-requester queues with the
// data the blockram should return, and popped when the matching valid is
// expected. Directed sequences check grant timing, burst limits, write
// strobes, idle address hold, reset behaviour and the contention counter.
// ---------------------------------------------------------------------------
module tb_mem_port_arbiter;

    localparam int ADDR_W   = 16;
    localparam int DATA_W   = 16;
    localparam int MAX_HOLD = 8;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              CPU_Req = 1'b0;
    logic              CPU_Wr_En = 1'b0;
    logic [ADDR_W-1:0] CPU_Addr = '0;
    logic [DATA_W-1:0] CPU_Data_In = '0;
    logic              CPU_Grant;
    logic [DATA_W-1:0] CPU_Data_Out;
    logic              CPU_Data_Valid;
    logic              Vid_Req = 1'b0;
    logic [ADDR_W-1:0] Vid_Addr = '0;
    logic              Vid_Grant;
    logic [DATA_W-1:0] Vid_Data_Out;
    logic              Vid_Data_Valid;
    logic [ADDR_W-1:0] Mem_Addr;
    logic [DATA_W-1:0] Mem_Data_Out;
    logic              Mem_Wr_En;
    logic [DATA_W-1:0] Mem_Data_In = '0;
    logic [15:0]       Contention_Cnt;

    logic [DATA_W-1:0] mem [0:65535];

    int n_cmp = 0;
    int n_err = 0;

    logic [DATA_W-1:0] cpu_q[$];
    logic [DATA_W-1:0] vid_q[$];
    logic              cpu_pend = 1'b0;
    logic              vid_pend = 1'b0;

    mem_port_arbiter #(
        .ADDR_W   (ADDR_W),
        .DATA_W   (DATA_W),
        .MAX_HOLD (MAX_HOLD)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .CPU_Req        (CPU_Req),
        .CPU_Wr_En      (CPU_Wr_En),
        .CPU_Addr       (CPU_Addr),
        .CPU_Data_In    (CPU_Data_In),
        .CPU_Grant      (CPU_Grant),
        .CPU_Data_Out   (CPU_Data_Out),
        .CPU_Data_Valid (CPU_Data_Valid),
        .Vid_Req        (Vid_Req),
        .Vid_Addr       (Vid_Addr),
        .Vid_Grant      (Vid_Grant),
        .Vid_Data_Out   (Vid_Data_Out),
        .Vid_Data_Valid (Vid_Data_Valid),
        .Mem_Addr       (Mem_Addr),
        .Mem_Data_Out   (Mem_Data_Out),
        .Mem_Wr_En      (Mem_Wr_En),
        .Mem_Data_In    (Mem_Data_In),
        .Contention_Cnt (Contention_Cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] pat(input logic [15:0] a);
        return {a[7:0], a[15:8]} ^ 16'hC3A5;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset   = 1'b1;
        CPU_Req = 1'b0;
        Vid_Req = 1'b0;
        step();
        reset   = 1'b0;
    endtask

    // Behavioural synchronous blockram.
    always @(posedge clk) begin
        if (Mem_Wr_En) mem[Mem_Addr] <= Mem_Data_Out;
        Mem_Data_In <= mem[Mem_Addr];
    end

    // Scoreboard: pop expected read data when a valid is due, push on accepted reads.
    initial begin
        logic [DATA_W-1:0] exp_d;
        forever begin
            @(negedge clk);
            chk("cpu_vld", 32'(CPU_Data_Valid), 32'(cpu_pend));
            if (cpu_pend && cpu_q.size() > 0) begin
                exp_d = cpu_q.pop_front();
                chk("cpu_rdata", 32'(CPU_Data_Out), 32'(exp_d));
            end
            chk("vid_vld", 32'(Vid_Data_Valid), 32'(vid_pend));
            if (vid_pend && vid_q.size() > 0) begin
                exp_d = vid_q.pop_front();
                chk("vid_rdata", 32'(Vid_Data_Out), 32'(exp_d));
            end
            if (reset) begin
                cpu_q.delete();
                vid_q.delete();
                cpu_pend = 1'b0;
                vid_pend = 1'b0;
            end else begin
                cpu_pend = CPU_Grant && CPU_Req && !CPU_Wr_En;
                vid_pend = Vid_Grant && Vid_Req;
                if (cpu_pend) cpu_q.push_back(mem[CPU_Addr]);
                if (vid_pend) vid_q.push_back(mem[Vid_Addr]);
            end
        end
    end

    initial begin
        #3000000;
        $display("FAIL timeout: simulation did not finish, n_err=%0d", n_err);
        $fatal(1, "timeout");
    end

    initial begin
        logic exp_cpu;
        for (int a = 0; a < 65536; a++) mem[a] = pat(16'(a));

        // Reset and a single CPU read.
        repeat (3) @(posedge clk);
        #1;
        reset    = 1'b0;
        CPU_Req  = 1'b1;
        CPU_Wr_En = 1'b0;
        CPU_Addr = 16'h0900;
        #1;
        chk("rst_cpu_gnt", 32'(CPU_Grant), 32'd0);
        chk("rst_vid_gnt", 32'(Vid_Grant), 32'd0);
        chk("rst_cpu_vld", 32'(CPU_Data_Valid), 32'd0);
        chk("rst_vid_vld", 32'(Vid_Data_Valid), 32'd0);
        chk("rst_cnt", 32'(Contention_Cnt), 32'd0);
        chk("rst_wr_en", 32'(Mem_Wr_En), 32'd0);

        step(); #1;
        chk("t1_cpu_gnt", 32'(CPU_Grant), 32'd1);
        chk("t1_vid_gnt", 32'(Vid_Grant), 32'd0);
        chk("t1_mem_addr", 32'(Mem_Addr), 32'h0900);
        chk("t1_wr_en", 32'(Mem_Wr_En), 32'd0);
        step(); CPU_Req = 1'b0; #1;
        chk("t1_cpu_vld", 32'(CPU_Data_Valid), 32'd1);
        chk("t1_cpu_dout", 32'(CPU_Data_Out), 32'(pat(16'h0900)));
        chk("t1_vid_gnt2", 32'(Vid_Grant), 32'd0);
        step(); CPU_Addr = 16'h7777; #1;
        chk("t1_idle_gnt", 32'(CPU_Grant), 32'd0);
        chk("t1_idle_addr", 32'(Mem_Addr), 32'h0900);
        step(); #1;
        chk("t1_idle_addr2", 32'(Mem_Addr), 32'h0900);

        // Contended round robin with MAX_HOLD bursts.
        do_reset();
        CPU_Req  = 1'b1;
        Vid_Req  = 1'b1;
        CPU_Addr = 16'h1000;
        Vid_Addr = 16'h2000;
        #1;
        chk("t2_c0_cpu_gnt", 32'(CPU_Grant), 32'd0);
        chk("t2_c0_cnt", 32'(Contention_Cnt), 32'd0);
        for (int c = 1; c <= 32; c++) begin
            step();
            if (CPU_Grant) CPU_Addr = 16'(32'h1000 + c);
            if (Vid_Grant) Vid_Addr = 16'(32'h2000 + c);
            #1;
            exp_cpu = (((c - 1) / MAX_HOLD) % 2) == 0;
            chk("t2_cpu_gnt", 32'(CPU_Grant), 32'(exp_cpu));
            chk("t2_vid_gnt", 32'(Vid_Grant), 32'(!exp_cpu));
            chk("t2_wr_en", 32'(Mem_Wr_En), 32'd0);
`ifdef ARB_STATS_EN
            chk("t2_cnt", 32'(Contention_Cnt), 32'(c - 1));
`else
            chk("t2_cnt", 32'(Contention_Cnt), 32'd0);
`endif
        end
        step(); CPU_Req = 1'b0; Vid_Req = 1'b0; #1;
        chk("t2_c33_cpu_gnt", 32'(CPU_Grant), 32'd1);
`ifdef ARB_STATS_EN
        chk("t2_cnt_final", 32'(Contention_Cnt), 32'd32);
`else
        chk("t2_cnt_final", 32'(Contention_Cnt), 32'd0);
`endif
        step(); #1;
        chk("t2_idle_cpu", 32'(CPU_Grant), 32'd0);
        chk("t2_idle_vid", 32'(Vid_Grant), 32'd0);

        // CPU write queued behind a video burst.
        step(); Vid_Req = 1'b1; Vid_Addr = 16'h4000; #1;
        chk("t3_wr_idle", 32'(Mem_Wr_En), 32'd0);
        step();
        CPU_Req = 1'b1; CPU_Wr_En = 1'b1; CPU_Addr = 16'h1234; CPU_Data_In = 16'hBEEF;
        #1;
        chk("t3_vid_gnt", 32'(Vid_Grant), 32'd1);
        chk("t3_wr_vid", 32'(Mem_Wr_En), 32'd0);
        chk("t3_addr_vid", 32'(Mem_Addr), 32'h4000);
        step(); Vid_Req = 1'b0; #1;
        chk("t3_vid_gnt2", 32'(Vid_Grant), 32'd1);
        chk("t3_wr_vid2", 32'(Mem_Wr_En), 32'd0);
        step(); #1;
        chk("t3_cpu_gnt", 32'(CPU_Grant), 32'd1);
        chk("t3_wr_en", 32'(Mem_Wr_En), 32'd1);
        chk("t3_wr_addr", 32'(Mem_Addr), 32'h1234);
        chk("t3_wr_data", 32'(Mem_Data_Out), 32'hBEEF);
        step(); CPU_Wr_En = 1'b0; #1;
        chk("t3_wr_once", 32'(Mem_Wr_En), 32'd0);
        chk("t3_no_wr_vld", 32'(CPU_Data_Valid), 32'd0);
        step(); CPU_Req = 1'b0; #1;
        chk("t3_rb_vld", 32'(CPU_Data_Valid), 32'd1);
        chk("t3_rb_data", 32'(CPU_Data_Out), 32'hBEEF);
        step(); step();

        // Uncontended 20-access video burst.
        step(); Vid_Req = 1'b1; Vid_Addr = 16'h3000; #1;
        for (int c = 1; c <= 22; c++) begin
            step();
            if (c == 21) Vid_Req = 1'b0;
            if (c <= 20) Vid_Addr = 16'(32'h3000 + c);
            #1;
            chk("t4_vid_gnt", 32'(Vid_Grant), 32'(c <= 21));
            chk("t4_vid_vld", 32'(Vid_Data_Valid), 32'(c >= 2 && c <= 21));
            chk("t4_cpu_gnt", 32'(CPU_Grant), 32'd0);
        end

        // Reset mid video burst with a CPU request pending.
        step(); Vid_Req = 1'b1; Vid_Addr = 16'h5000; #1;
        step(); #1;
        chk("t5_vid_gnt", 32'(Vid_Grant), 32'd1);
        step();
        CPU_Req = 1'b1; CPU_Wr_En = 1'b0; CPU_Addr = 16'h0A00; reset = 1'b1;
        #1;
        step(); reset = 1'b0; #1;
        chk("t5_cpu_gnt0", 32'(CPU_Grant), 32'd0);
        chk("t5_vid_gnt0", 32'(Vid_Grant), 32'd0);
        chk("t5_cpu_vld0", 32'(CPU_Data_Valid), 32'd0);
        chk("t5_vid_vld0", 32'(Vid_Data_Valid), 32'd0);
        chk("t5_cnt0", 32'(Contention_Cnt), 32'd0);
        step(); #1;
        chk("t5_cpu_gnt", 32'(CPU_Grant), 32'd1);
        chk("t5_vid_gnt", 32'(Vid_Grant), 32'd0);
        chk("t5_addr", 32'(Mem_Addr), 32'h0A00);
        step(); CPU_Req = 1'b0; Vid_Req = 1'b0; #1;
        chk("t5_cpu_vld", 32'(CPU_Data_Valid), 32'd1);
        step(); step(); step();

`ifdef ARB_STATS_EN
        // Long contended run drives the counter into saturation.
        CPU_Req = 1'b1; Vid_Req = 1'b1; CPU_Addr = 16'h0100; Vid_Addr = 16'h0200;
        repeat (65540) step();
        #1;
        chk("t6_cnt_sat", 32'(Contention_Cnt), 32'hFFFF);
        step(); #1;
        chk("t6_cnt_sat2", 32'(Contention_Cnt), 32'hFFFF);
        CPU_Req = 1'b0; Vid_Req = 1'b0;
        step(); step();
`else
        chk("t6_cnt_zero", 32'(Contention_Cnt), 32'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single main data blockram port between two requesters: the CPU data port (read/write) and the video fetch engine (read-only).
- Sits between the CPU-side memory controller and the main data blockram.
- Round-robin ownership, a bounded hold (burst) length, and a one-cycle read-valid pipeline matching synchronous blockram read latency.

Parameters:
- ADDR_W, 16, width of all address buses
- DATA_W, 16, width of all data buses
- MAX_HOLD, 8, maximum consecutive accesses one owner may make while the other requester waits (range 1..255)

Ports:
- clk  in  1  system clock, all logic on rising edge
- reset  in  1  synchronous, active-high reset
- CPU_Req  in  1  CPU requests an access this cycle
- CPU_Wr_En  in  1  CPU access is a write (qualified by CPU_Req and CPU_Grant)
- CPU_Addr  in  ADDR_W  CPU access address
- CPU_Data_In  in  DATA_W  CPU write data
- CPU_Grant  out  1  CPU owns the port; an access occurs every cycle CPU_Req && CPU_Grant
- CPU_Data_Out  out  DATA_W  read data to CPU
- CPU_Data_Valid  out  1  CPU_Data_Out holds data for the CPU read accepted last cycle
- Vid_Req  in  1  video requests a read this cycle
- Vid_Addr  in  ADDR_W  video read address
- Vid_Grant  out  1  video owns the port
- Vid_Data_Out  out  DATA_W  read data to video
- Vid_Data_Valid  out  1  Vid_Data_Out holds data for the video read accepted last cycle
- Mem_Addr  out  ADDR_W  blockram address
- Mem_Data_Out  out  DATA_W  blockram write data
- Mem_Wr_En  out  1  blockram write enable
- Mem_Data_In  in  DATA_W  blockram read data, valid one cycle after the address
- Contention_Cnt  out  16  contention statistic (see Optional Feature)

Behaviour:
- Owner register states: IDLE, CPU_OWN, VID_OWN. CPU_Grant = (state==CPU_OWN); Vid_Grant = (state==VID_OWN). Both grants are registered, never both high.
- Last_served bit: reset value VID, so the CPU wins the first tie.
- Accesses: access = owner's Req high while that owner's Grant is high. One access per cycle, no bubbles within a burst.
- Mem_Addr mux:
  - CPU_OWN: CPU_Addr.
  - VID_OWN: Vid_Addr.
  - IDLE: holds the last driven value; value is don't-care but must be stable.
- Mem_Data_Out = CPU_Data_In always.
- Mem_Wr_En = CPU_OWN && CPU_Req && CPU_Wr_En. Combinational, never high in any other state.
- Read valid: CPU_Data_Valid / Vid_Data_Valid are registered. High exactly one cycle after a read access by that owner (CPU writes produce no valid). CPU_Data_Out = Vid_Data_Out = Mem_Data_In.
- Hold counter: counts accesses by the current owner. Cleared on every state change. Saturates at MAX_HOLD.
- Transitions (evaluated each clock):
  - IDLE: both Req high → grant the requester != Last_served. One Req high → grant it. Neither → stay.
  - X_OWN, X_Req high, other Req low → stay; burst is unbounded when uncontended.
  - X_OWN, X_Req high, other Req high, hold count reached MAX_HOLD → switch directly to the other owner (no IDLE cycle). Set Last_served = X.
  - X_OWN, X_Req low, other Req high → switch directly to the other owner.
  - X_OWN, X_Req low, other Req low → IDLE.
- Grant latency: from Req rising with the port idle, Grant is high the next cycle. Worst-case wait while contended is MAX_HOLD+1 cycles.
- Requester contract: a requester holds Req, Addr and Wr_En stable until it sees its Grant.
- Reset (including mid-burst): state IDLE, grants 0, valids 0, hold count 0, Last_served VID, Contention_Cnt 0. Any pending read valid is discarded.

Optional Feature:
- Macro ARB_STATS_EN.
- Defined: Contention_Cnt increments each cycle in which a requester has Req high and its Grant low while the other requester holds the grant. At most +1 per cycle. Saturates at 0xFFFF. Cleared only by reset.
- Undefined: Contention_Cnt is tied to 0 and no counter logic is generated. The port list is identical in both builds.

Test Plan:
- Reset, then CPU_Req=1 read, CPU_Addr=0x0900 → CPU_Grant high cycle 1, Mem_Addr=0x0900, CPU_Data_Valid high cycle 2 with Mem_Data_In; Vid_Grant stays 0.
- CPU_Req and Vid_Req both rise the first cycle after reset → CPU granted first. With both held, MAX_HOLD=8: exactly 8 CPU accesses, then Vid_Grant with no idle cycle, 8 video accesses, then back to CPU.
- CPU write 0xBEEF to 0x1234 while VID_OWN, then ownership switches → Mem_Wr_En high for exactly one cycle, only while CPU_Grant, Mem_Addr=0x1234, Mem_Data_Out=0xBEEF. Mem_Wr_En never high during VID_OWN.
- Vid_Req alone held for 20 cycles → 20 consecutive accesses, Vid_Data_Valid high cycles 2..21; hold limit is not applied while uncontended.
- Assert reset mid-video-burst with CPU_Req pending → next cycle all grants and valids 0, state IDLE; after release, CPU granted one cycle later.
- ARB_STATS_EN build, contended run from the MAX_HOLD=8 scenario over 32 cycles → Contention_Cnt equals the count of waiting cycles. Preload-by-run to 0xFFFF → stays 0xFFFF. Non-EN build → Contention_Cnt=0 throughout.
